// File: rtl/z_stream_reader_if.sv
// Bus bundle for z_stream_reader: start/config, z RAM read port and output stream.
// Optional macro Z_STREAM_CHECKSUM_EN adds the checksum signal.
interface z_stream_reader_if;
    logic        start;
    logic [17:0] base_addr;
    logic [15:0] num_vec;
    logic [17:0] address;
    logic        we;
    logic [31:0] ram_q;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;
`ifdef Z_STREAM_CHECKSUM_EN
    logic [31:0] checksum;

    modport master (
        output start, base_addr, num_vec, ram_q, out_ready,
        input  address, we, out_data, out_valid, out_last, busy, done, checksum
    );
    modport slave (
        input  start, base_addr, num_vec, ram_q, out_ready,
        output address, we, out_data, out_valid, out_last, busy, done, checksum
    );
`else
    modport master (
        output start, base_addr, num_vec, ram_q, out_ready,
        input  address, we, out_data, out_valid, out_last, busy, done
    );
    modport slave (
        input  start, base_addr, num_vec, ram_q, out_ready,
        output address, we, out_data, out_valid, out_last, busy, done
    );
`endif
endinterface

// File: rtl/z_stream_reader.sv
// Streams num_vec*VEC_LEN words from the z RAM through a 2-entry output FIFO.
// Optional macro Z_STREAM_CHECKSUM_EN adds a running 32-bit sum of transferred words.
module z_stream_reader #(
    parameter int unsigned VEC_LEN = 16
) (
    input  logic clk,
    input  logic rst,
    z_stream_reader_if.slave zs
);
    localparam int unsigned IW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t        r_state, w_state_nxt;
    logic [17:0]   r_addr;
    logic [17:0]   r_addr_last;
    logic [25:0]   r_remain;
    logic [IW-1:0] r_widx;
    logic          r_infl, r_infl_last, r_infl_final;
    logic [31:0]   r_fifo_data  [2];
    logic          r_fifo_last  [2];
    logic          r_fifo_final [2];
    logic          r_wp, r_rp;
    logic [1:0]    r_cnt;
    logic          r_zdone;

    logic          w_accept, w_pop, w_push, w_issue, w_idx_last, w_final_issue;
    logic          w_head_final;

    // Address is presented combinationally in the issue cycle so the one-deep
    // in-flight slot plus the 2-entry FIFO can sustain one word per cycle.
    always_comb begin
        w_accept      = (r_state == S_IDLE) && zs.start;
        w_pop         = (r_cnt != 2'd0) && zs.out_ready;
        w_push        = r_infl;
        w_head_final  = r_fifo_final[r_rp];
        w_issue       = (r_state == S_ISSUE) &&
                        (({1'b0, r_cnt} + {2'b00, r_infl} - {2'b00, w_pop}) < 3'd2);
        w_idx_last    = (r_widx == IW'(VEC_LEN - 1));
        w_final_issue = w_issue && (r_remain == 26'd1);

        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (zs.start && (zs.num_vec != '0)) w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_final_issue)                  w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_pop && w_head_final)          w_state_nxt = S_IDLE;
            default:                                     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_addr_last  <= '0;
            r_remain     <= '0;
            r_widx       <= '0;
            r_infl       <= 1'b0;
            r_infl_last  <= 1'b0;
            r_infl_final <= 1'b0;
            r_wp         <= 1'b0;
            r_rp         <= 1'b0;
            r_cnt        <= '0;
            r_zdone      <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_fifo_data[i]  <= '0;
                r_fifo_last[i]  <= 1'b0;
                r_fifo_final[i] <= 1'b0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_zdone <= w_accept && (zs.num_vec == '0);

            if (w_accept) begin
                r_addr   <= zs.base_addr;
                r_remain <= 26'(zs.num_vec) * 26'(VEC_LEN);
                r_widx   <= '0;
            end else if (w_issue) begin
                r_addr      <= r_addr + 18'd1;
                r_addr_last <= r_addr;
                r_remain    <= r_remain - 26'd1;
                r_widx      <= w_idx_last ? '0 : r_widx + IW'(1);
            end

            r_infl       <= w_issue;
            r_infl_last  <= w_idx_last;
            r_infl_final <= w_final_issue;

            if (w_push) begin
                r_fifo_data[r_wp]  <= zs.ram_q;
                r_fifo_last[r_wp]  <= r_infl_last;
                r_fifo_final[r_wp] <= r_infl_final;
                r_wp               <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign zs.address   = w_issue ? r_addr : r_addr_last;
    assign zs.we        = 1'b0;
    assign zs.out_valid = (r_cnt != 2'd0);
    assign zs.out_data  = r_fifo_data[r_rp];
    assign zs.out_last  = (r_cnt != 2'd0) && r_fifo_last[r_rp];
    assign zs.busy      = (r_state != S_IDLE);
    assign zs.done      = r_zdone || (w_pop && w_head_final);

`ifdef Z_STREAM_CHECKSUM_EN
    logic [31:0] r_sum;

    always_ff @(posedge clk) begin
        if (rst)           r_sum <= '0;
        else if (w_accept) r_sum <= '0;
        else if (w_pop)    r_sum <= r_sum + r_fifo_data[r_rp];
    end

    // Include the word transferring this cycle so the sum is complete when done pulses.
    assign zs.checksum = w_pop ? (r_sum + r_fifo_data[r_rp]) : r_sum;
`endif
endmodule

// File: tb/tb_z_stream_reader.sv
// Scoreboard bench for z_stream_reader (VEC_LEN=4); checksum checks under Z_STREAM_CHECKSUM_EN.
module tb_z_stream_reader;
    localparam int unsigned VL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    z_stream_reader_if zs();
    z_stream_reader #(.VEC_LEN(VL)) dut (.clk(clk), .rst(rst), .zs(zs));

    logic [31:0] mem [0:262143];
    always @(posedge clk) zs.ram_q <= mem[zs.address];

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        fin;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          total = 0;
    int          bad   = 0;
    int          xfers = 0;
    int          dones = 0;
    logic [31:0] cks_at_done = '0;
    bit          chk_lead = 1'b0;
    logic [17:0] nxt_addr = '0;
    logic [17:0] lead;
    bit          stalled = 1'b0;
    logic [31:0] st_data;
    logic        st_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer, checks stall stability and address lead.
    always @(negedge clk) begin
        if (stalled) begin
            check("stall_valid", zs.out_valid, 1);
            check("stall_data", zs.out_data, st_data);
            check("stall_last", zs.out_last, st_last);
        end
        if (zs.done === 1'b1) begin
            dones++;
`ifdef Z_STREAM_CHECKSUM_EN
            cks_at_done = zs.checksum;
`endif
        end
        if (chk_lead && zs.busy === 1'b1) begin
            lead = zs.address - nxt_addr;
            check("addr_lead_le2", (lead <= 18'd2), 1);
        end
        if (zs.out_valid === 1'b1 && zs.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %h expected none", zs.out_data);
            end else begin
                e = sb.pop_front();
                check("word_data", zs.out_data, e.data);
                check("word_last", zs.out_last, e.last);
                check("word_done", zs.done, e.fin);
            end
            xfers++;
            nxt_addr = nxt_addr + 18'd1;
        end
        stalled = (zs.out_valid === 1'b1) && (zs.out_ready === 1'b0);
        st_data = zs.out_data;
        st_last = zs.out_last;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [17:0] base, input logic [15:0] nv);
        @(posedge clk);
        #1;
        zs.start     = 1'b1;
        zs.base_addr = base;
        zs.num_vec   = nv;
        @(posedge clk);
        #1;
        zs.start     = 1'b0;
    endtask

    task automatic push_burst(input logic [17:0] base, input int nv);
        logic [17:0] a;
        for (int k = 0; k < nv * int'(VL); k++) begin
            a = base + 18'(k);
            sb.push_back('{mem[a], ((k % int'(VL)) == int'(VL) - 1), (k == nv * int'(VL) - 1)});
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i = 0;
        while ((sb.size() != 0 || zs.busy !== 1'b0) && i < budget) begin
            tick();
            i++;
        end
        check({name, "_drained"}, (i < budget), 1);
        check({name, "_sb_empty"}, 32'(sb.size()), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_address"},   zs.address, 0);
        check({name, "_out_valid"}, zs.out_valid, 0);
        check({name, "_out_last"},  zs.out_last, 0);
        check({name, "_out_data"},  zs.out_data, 0);
        check({name, "_busy"},      zs.busy, 0);
        check({name, "_done"},      zs.done, 0);
        check({name, "_we"},        zs.we, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, x0, i;
        logic [17:0] a0;

        for (int a = 0; a < 262144; a++) mem[a] = 32'hA500_0000 | 32'(a);
        zs.start     = 1'b0;
        zs.base_addr = '0;
        zs.num_vec   = '0;
        zs.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        tick();
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two 4-word vectors from 0x10 at full rate
        d0 = dones;
        nxt_addr = 18'h00010;
        push_burst(18'h00010, 2);
        drive_start(18'h00010, 16'd2);
        tick();
        check("lat_c1_busy", zs.busy, 1);
        check("lat_c1_valid", zs.out_valid, 0);
        tick();
        check("lat_c2_valid", zs.out_valid, 0);
        tick();
        check("lat_c3_valid", zs.out_valid, 1);
        i = 0;
        while (zs.done !== 1'b1 && i < 20) begin
            tick();
            i++;
        end
        check("burst_cycles_to_done", i, 7);
        tick();
        check("busy_after_done", zs.busy, 0);
        check("burst_done_count", dones - d0, 1);
        check("burst_sb_empty", 32'(sb.size()), 0);

        // Address wrap at the top of the 18-bit space
        push_burst(18'h3FFFE, 1);
        drive_start(18'h3FFFE, 16'd1);
        wait_idle("wrap", 100);

        // Zero-length burst
        a0 = zs.address;
        d0 = dones;
        drive_start(18'h00155, 16'd0);
        tick();
        check("zero_done", zs.done, 1);
        check("zero_busy", zs.busy, 0);
        check("zero_addr", zs.address, a0);
        tick();
        check("zero_done_once", zs.done, 0);
        repeat (3) tick();
        check("zero_done_count", dones - d0, 1);

        // Start during a burst must be ignored
        d0 = dones;
        push_burst(18'h00100, 2);
        drive_start(18'h00100, 16'd2);
        repeat (3) tick();
        drive_start(18'h00200, 16'd5);
        wait_idle("ignore", 100);
        repeat (10) tick();
        check("ignore_no_extra_valid", zs.out_valid, 0);
        check("ignore_done_count", dones - d0, 1);

        // 128 words with random back-pressure
        nxt_addr = 18'h02000;
        push_burst(18'h02000, 32);
        chk_lead = 1'b1;
        drive_start(18'h02000, 16'd32);
        i = 0;
        while (sb.size() != 0 && i < 5000) begin
            @(posedge clk);
            #1;
            zs.out_ready = 1'($urandom_range(0, 1));
            i++;
        end
        zs.out_ready = 1'b1;
        wait_idle("random", 100);
        chk_lead = 1'b0;

        // Reset on the 5th transfer of a 32-word burst
        d0 = dones;
        x0 = xfers;
        push_burst(18'h00400, 8);
        drive_start(18'h00400, 16'd8);
        i = 0;
        while ((xfers - x0) < 4 && i < 100) begin
            tick();
            i++;
        end
        check("rst_reached_4th", (i < 100), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        tick();
        check_reset_outputs("midrst");
        repeat (4) tick();
        check("midrst_no_valid", zs.out_valid, 0);
        check("midrst_no_done", dones - d0, 0);
        nxt_addr = 18'h00030;
        push_burst(18'h00030, 1);
        drive_start(18'h00030, 16'd1);
        wait_idle("after_rst", 100);
        check("after_rst_done_count", dones - d0, 1);

`ifdef Z_STREAM_CHECKSUM_EN
        for (int k = 0; k < 8; k++) mem[18'h00500 + 18'(k)] = 32'(k + 1);
        push_burst(18'h00500, 2);
        drive_start(18'h00500, 16'd2);
        wait_idle("cks_a", 100);
        check("checksum_36", cks_at_done, 32'd36);
        mem[18'h00600] = 32'hFFFF_FFFF;
        mem[18'h00601] = 32'h0000_0002;
        mem[18'h00602] = 32'h0000_0000;
        mem[18'h00603] = 32'h0000_0000;
        push_burst(18'h00600, 1);
        drive_start(18'h00600, 16'd1);
        wait_idle("cks_b", 100);
        check("checksum_wrap", cks_at_done, 32'h0000_0001);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/z_stream_reader.md
Z_STREAM_READER -- requirements
Module: z_stream_reader

Interface
REQ-001 Parameter VEC_LEN, default 16: 32-bit words per z vector; legal range 1..1024.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-005 base_addr  input  18  first word address, latched on accepted start.
REQ-006 num_vec  input  16  vectors to stream, latched on accepted start.
REQ-007 address  output  18  read address driven to the z RAM.
REQ-008 we  output  1  z RAM write enable; constant 0.
REQ-009 ram_q  input  32  z RAM data_out; valid one cycle after the address is presented.
REQ-010 out_data  output  32  streamed word.
REQ-011 out_valid  output  1  out_data holds a valid word.
REQ-012 out_ready  input  1  consumer accepts; a transfer occurs when out_valid and out_ready are both 1.
REQ-013 out_last  output  1  current word is word VEC_LEN-1 of its vector.
REQ-014 busy  output  1  high from the cycle after an accepted start until done.
REQ-015 done  output  1  one-cycle pulse when the final word transfers, or when a zero-length burst completes.

Function
REQ-016 States: IDLE, ISSUE, DRAIN. IDLE->ISSUE on start with num_vec!=0. ISSUE->DRAIN after the last read issues. DRAIN->IDLE on the final transfer.
REQ-017 start with num_vec=0: no reads are issued, busy stays 0, and done pulses on the following cycle.
REQ-018 start while not in IDLE is ignored. base_addr and num_vec are not re-sampled.
REQ-019 Total words = num_vec*VEC_LEN. Address k = (base_addr + k) mod 2^18, wrapping from 0x3FFFF to 0x00000.
REQ-020 A read is issued in a cycle by advancing address. Returned data is captured from ram_q exactly one cycle later into a 2-entry output FIFO.
REQ-021 Issue is permitted only when FIFO occupancy + in-flight reads < 2, counting a same-cycle pop as freeing one slot. The FIFO never overflows.
REQ-022 With out_ready held at 1, the block sustains 1 word per cycle. The first out_valid appears 2 cycles after start is accepted.
REQ-023 out_data, out_valid and out_last are stable while out_valid=1 and out_ready=0.
REQ-024 out_last is derived from a word counter modulo VEC_LEN that travels with each word through the FIFO.
REQ-025 Words are delivered in address order, with no loss or duplication under any out_ready pattern.
REQ-026 address holds its last value when no read is issued.

Reset
REQ-027 On rst: state=IDLE, address=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0, FIFO empty, counters 0, in-flight cleared.
REQ-028 rst asserted mid-burst aborts the burst. No done pulse is generated, and ram_q returning in the next cycle is discarded.
REQ-029 rst has priority over start in the same cycle.

Configuration
REQ-030 Macro Z_STREAM_CHECKSUM_EN, when defined, adds output checksum[31:0]:
- checksum clears on an accepted start;
- it accumulates the wrapping 32-bit sum of every transferred word;
- it is valid when done pulses and holds until the next start;
- reset value is 0.
REQ-031 Without Z_STREAM_CHECKSUM_EN, the checksum port and its logic do not exist. All other behaviour is identical.

Verification
REQ-032 VEC_LEN=4, base_addr=0x00010, num_vec=2, out_ready=1:
- 8 words from 0x10..0x17 in order;
- out_last on words 3 and 7;
- done on the cycle of word 7;
- busy low the next cycle.
REQ-033 base_addr=0x3FFFE, num_vec=1, VEC_LEN=4: addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
REQ-034 out_ready random 50% over num_vec=8, VEC_LEN=16:
- all 128 words match the memory model in order;
- out_data is stable while stalled;
- address never leads the FIFO by more than 2.
REQ-035 start with num_vec=0: no address change, busy=0, done pulses once 1 cycle later; a second start during a burst is ignored.
REQ-036 rst asserted on the 5th transfer of a 32-word burst:
- all outputs go to reset values the next cycle;
- no done pulse;
- a new start streams correctly from its base_addr.
REQ-037 With Z_STREAM_CHECKSUM_EN, memory words 1..8 at the burst addresses give checksum=36 at done; words 0xFFFFFFFF and 0x2 give 0x00000001.
